// File: rtl/multibyte_adder_seq_if.sv
// Request/result bundle between a wide-operand requester and the limb-serial adder.
// The requester drives the operands and START; the adder returns BUSY/DONE and the result.
interface multibyte_adder_seq_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         START;
  logic         SUB;
  logic         CI;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         CO;

  modport master (
    output START, SUB, CI, A, B,
    input  BUSY, DONE, SUM, CO
  );

  modport slave (
    input  START, SUB, CI, A, B,
    output BUSY, DONE, SUM, CO
  );
endinterface

// File: rtl/multibyte_adder_seq.sv
// Wide add/subtract built from one 8-bit adder slice, one limb per clock, LSB first,
// with the carry rippled through a register between limbs.
module multibyte_adder_seq #(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  multibyte_adder_seq_if.slave  bus
);
  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q,     a_d;
  logic [W-1:0]     b_q,     b_d;
  logic             sub_q,   sub_d;
  logic [W-1:0]     sum_q,   sum_d;
  logic             co_q,    co_d;

  logic [IDX_W+2:0] limb_base;
  logic [7:0]       a_limb;
  logic [7:0]       b_limb;
  logic [8:0]       limb_res;

  // 9-bit result keeps the carry out of the slice.
  function automatic logic [8:0] limb_add(input logic [7:0] a, input logic [7:0] b,
                                          input logic sub, input logic cin);
    logic [7:0] b_eff;
    b_eff = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_eff} + {8'd0, cin};
  endfunction

  assign limb_base = {idx_q, 3'b000};
  assign a_limb    = a_q[limb_base +: 8];
  assign b_limb    = b_q[limb_base +: 8];
  assign limb_res  = limb_add(a_limb, b_limb, sub_q, carry_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    co_d    = co_q;
    case (state_q)
      S_IDLE: begin
        if (bus.START) begin
          a_d     = bus.A;
          b_d     = bus.B;
          sub_d   = bus.SUB;
          carry_d = bus.CI;
          idx_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[limb_base +: 8] = limb_res[7:0];
        carry_d               = limb_res[8];
        if (idx_q == IDX_LAST) begin
          co_d    = limb_res[8];
          idx_d   = '0;
          state_d = S_FIN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  // Outputs come straight from registers; no input reaches them combinationally.
  assign bus.BUSY = (state_q == S_ADD);
  assign bus.DONE = (state_q == S_FIN);
  assign bus.SUM  = sum_q;
  assign bus.CO   = co_q;
endmodule

// File: tb/tb_multibyte_adder_seq.sv
// Randomized and directed bench for multibyte_adder_seq, 4-limb and 1-limb instances,
// checked against a whole-word arithmetic reference.
module tb_multibyte_adder_seq;
  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multibyte_adder_seq_if #(.NBYTES(NB)) if4 ();
  multibyte_adder_seq_if #(.NBYTES(1))  if1 ();

  multibyte_adder_seq #(.NBYTES(NB)) dut4 (.CLK(clk), .RST(rst), .bus(if4.slave));
  multibyte_adder_seq #(.NBYTES(1))  dut1 (.CLK(clk), .RST(rst), .bus(if1.slave));

  int vec  = 0;
  int errs = 0;

  function automatic logic [W:0] ref4(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic sub, input logic ci);
    logic [W-1:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + (W+1)'(ci);
  endfunction

  function automatic logic [8:0] ref1(input logic [7:0] a, input logic [7:0] b,
                                      input logic sub, input logic ci);
    logic [7:0] bb;
    bb = sub ? ~b : b;
    return {1'b0, a} + {1'b0, bb} + 9'(ci);
  endfunction

  // One START pulse, then operands scrambled while the DUT works.
  task automatic run_op4(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub, input logic ci,
                         output logic [W-1:0] sum_at_start, output logic [W-1:0] got_sum,
                         output logic got_co, output int busy_cnt, output int done_k,
                         output logic done_after);
    if4.A = a; if4.B = b; if4.SUB = sub; if4.CI = ci; if4.START = 1'b1;
    @(posedge clk); #1;
    if4.START = 1'b0;
    if4.A = $urandom; if4.B = $urandom; if4.SUB = 1'($urandom); if4.CI = 1'($urandom);
    sum_at_start = if4.SUM;
    busy_cnt = 0;
    done_k   = -1;
    for (int k = 1; k <= 20; k++) begin
      if (if4.BUSY) busy_cnt++;
      if (if4.DONE) begin
        done_k = k;
        break;
      end
      @(posedge clk); #1;
    end
    got_sum = if4.SUM;
    got_co  = if4.CO;
    @(posedge clk); #1;
    done_after = if4.DONE;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    if4.START = 1'b0; if4.SUB = 1'b0; if4.CI = 1'b0; if4.A = '0; if4.B = '0;
    if1.START = 1'b0; if1.SUB = 1'b0; if1.CI = 1'b0; if1.A = '0; if1.B = '0;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (if4.BUSY !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", if4.BUSY); end
    vec++; if (if4.DONE !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", if4.DONE); end
    vec++; if (if4.SUM !== '0) begin errs++; $display("FAIL reset_sum: got %h expected 0", if4.SUM); end
    vec++; if (if4.CO !== 1'b0) begin errs++; $display("FAIL reset_co: got %b expected 0", if4.CO); end
    vec++; if (if1.SUM !== '0 || if1.BUSY !== 1'b0) begin errs++; $display("FAIL reset_nb1: got sum %h busy %b expected 0 0", if1.SUM, if1.BUSY); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [4] = '{32'h000000FF, 32'hFFFFFFFF, 32'h00000005, 32'h00000007};
    logic [W-1:0] tb [4] = '{32'h00000001, 32'h00000000, 32'h00000007, 32'h00000005};
    logic         ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic         tc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] es [4] = '{32'h00000100, 32'h00000000, 32'hFFFFFFFE, 32'h00000002};
    logic         ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [W-1:0] prev, s0, s;
    logic co, da;
    int bc, dk;
    prev = '0;
    for (int i = 0; i < 4; i++) begin
      run_op4(ta[i], tb[i], ts[i], tc[i], s0, s, co, bc, dk, da);
      vec++; if (s0 !== prev) begin errs++; $display("FAIL dir%0d_sum_held: got %h expected %h", i, s0, prev); end
      vec++; if (bc != NB) begin errs++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, bc, NB); end
      vec++; if (dk != NB + 1) begin errs++; $display("FAIL dir%0d_done_cycle: got %0d expected %0d", i, dk, NB + 1); end
      vec++; if (s !== es[i]) begin errs++; $display("FAIL dir%0d_sum: got %h expected %h", i, s, es[i]); end
      vec++; if (co !== ec[i]) begin errs++; $display("FAIL dir%0d_co: got %b expected %b", i, co, ec[i]); end
      vec++; if (da !== 1'b0) begin errs++; $display("FAIL dir%0d_done_width: got %b expected 0", i, da); end
      prev = es[i];
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, s0, s;
    logic sub, ci, co, da;
    logic [W:0] exp;
    int bc, dk;
    for (int i = 0; i < 20; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom); ci = 1'($urandom);
      if (i == 0) begin a = '1; b = '1; sub = 1'b0; ci = 1'b1; end
      exp = ref4(a, b, sub, ci);
      run_op4(a, b, sub, ci, s0, s, co, bc, dk, da);
      vec++; if (s !== exp[W-1:0]) begin errs++; $display("FAIL rnd%0d_sum: got %h expected %h", i, s, exp[W-1:0]); end
      vec++; if (co !== exp[W]) begin errs++; $display("FAIL rnd%0d_co: got %b expected %b", i, co, exp[W]); end
      if4.A = $urandom; if4.B = $urandom;
      repeat (2) @(posedge clk);
      #1;
      vec++; if (if4.SUM !== exp[W-1:0] || if4.CO !== exp[W]) begin
        errs++; $display("FAIL rnd%0d_stable: got %h/%b expected %h/%b", i, if4.SUM, if4.CO, exp[W-1:0], exp[W]);
      end
    end
  endtask

  // START held high: accepts land every NB+2 edges, starting at edge 0.
  task automatic test_back_to_back;
    logic [W:0] expq [$];
    logic [W:0] e;
    int ph;
    for (int t = 0; t < 3 * (NB + 2); t++) begin
      if4.A = $urandom; if4.B = $urandom; if4.SUB = 1'($urandom); if4.CI = 1'($urandom);
      if4.START = 1'b1;
      ph = t % (NB + 2);
      if (ph == 0) expq.push_back(ref4(if4.A, if4.B, if4.SUB, if4.CI));
      @(posedge clk); #1;
      vec++; if (if4.DONE !== (ph == NB)) begin errs++; $display("FAIL b2b_done_t%0d: got %b expected %b", t, if4.DONE, (ph == NB)); end
      vec++; if (if4.BUSY !== (ph < NB)) begin errs++; $display("FAIL b2b_busy_t%0d: got %b expected %b", t, if4.BUSY, (ph < NB)); end
      if (ph == NB && expq.size() > 0) begin
        e = expq.pop_front();
        vec++; if ({if4.CO, if4.SUM} !== e) begin errs++; $display("FAIL b2b_result_t%0d: got %b/%h expected %b/%h", t, if4.CO, if4.SUM, e[W], e[W-1:0]); end
      end
    end
    if4.START = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    logic [W-1:0] s0, s, a, b;
    logic co, da, sub, ci;
    logic [W:0] exp;
    int bc, dk, dones;
    run_op4(32'h12345678, 32'h11111111, 1'b0, 1'b0, s0, s, co, bc, dk, da);
    if4.A = 32'hDEADBEEF; if4.B = 32'h01020304; if4.SUB = 1'b0; if4.CI = 1'b0; if4.START = 1'b1;
    @(posedge clk); #1;
    if4.START = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    vec++; if (if4.BUSY !== 1'b0 || if4.DONE !== 1'b0) begin errs++; $display("FAIL arst_ctrl: got busy %b done %b expected 0 0", if4.BUSY, if4.DONE); end
    vec++; if (if4.SUM !== '0) begin errs++; $display("FAIL arst_sum: got %h expected 0", if4.SUM); end
    vec++; if (if4.CO !== 1'b0) begin errs++; $display("FAIL arst_co: got %b expected 0", if4.CO); end
    dones = 0;
    for (int k = 0; k < NB + 2; k++) begin
      @(posedge clk); #1;
      if (if4.DONE) dones++;
    end
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < NB + 2; k++) begin
      @(posedge clk); #1;
      if (if4.DONE) dones++;
    end
    vec++; if (dones != 0) begin errs++; $display("FAIL arst_no_done: got %0d pulses expected 0", dones); end
    a = $urandom; b = $urandom; sub = 1'($urandom); ci = 1'($urandom);
    exp = ref4(a, b, sub, ci);
    run_op4(a, b, sub, ci, s0, s, co, bc, dk, da);
    vec++; if (s !== exp[W-1:0] || co !== exp[W]) begin errs++; $display("FAIL arst_after: got %h/%b expected %h/%b", s, co, exp[W-1:0], exp[W]); end
    vec++; if (dk != NB + 1) begin errs++; $display("FAIL arst_after_latency: got %0d expected %0d", dk, NB + 1); end
  endtask

  task automatic test_nbytes1;
    logic [7:0] a, b;
    logic sub, ci;
    logic [8:0] exp;
    int bc, dk;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom); ci = 1'($urandom);
      if (i == 0) begin a = 8'h80; b = 8'h80; sub = 1'b0; ci = 1'b1; end
      exp = ref1(a, b, sub, ci);
      if1.A = a; if1.B = b; if1.SUB = sub; if1.CI = ci; if1.START = 1'b1;
      @(posedge clk); #1;
      if1.START = 1'b0; if1.A = 8'($urandom); if1.B = 8'($urandom);
      bc = 0; dk = -1;
      for (int k = 1; k <= 10; k++) begin
        if (if1.BUSY) bc++;
        if (if1.DONE) begin dk = k; break; end
        @(posedge clk); #1;
      end
      vec++; if (bc != 1 || dk != 2) begin errs++; $display("FAIL nb1_%0d_timing: got busy %0d done %0d expected 1 2", i, bc, dk); end
      vec++; if ({if1.CO, if1.SUM} !== exp) begin errs++; $display("FAIL nb1_%0d_result: got %b/%h expected %b/%h", i, if1.CO, if1.SUM, exp[8], exp[7:0]); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_async_reset();
    test_nbytes1();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
